wb_master_bridge: RTL and testbench
===================================

WB_MASTER_BRIDGE -- requirements
Module: wb_master_bridge

Interface
REQ-001 Parameters SHALL be: TIMEOUT, default 255, number of stb cycles without ack before abort (legal range 1..65535).
REQ-002 Parameters SHALL be: ERR_DATA, default 32'hDEAD_BEEF, rsp_data value returned on timeout.
REQ-003 wb_clk_i SHALL be an input, 1 bit: the single clock; all state SHALL change on its rising edge.
REQ-004 wb_rst_n_i SHALL be an input, 1 bit: reset, asynchronous and active-low.
REQ-005 cmd_valid_i input 1, cmd_ready_o output 1: command handshake.
REQ-006 cmd_we_i input 1, cmd_sel_i input 4, cmd_adr_i input 32, cmd_dat_i input 32: command fields (write enable, byte selects, address, write data).
REQ-007 rsp_valid_o output 1, rsp_ready_i input 1: response handshake.
REQ-008 rsp_data_o output 32, rsp_err_o output 1: read data or ERR_DATA, timeout flag.
REQ-009 wbm_cyc_o, wbm_stb_o, wbm_we_o output 1 each; wbm_sel_o output 4; wbm_adr_o, wbm_dat_o output 32: Wishbone classic initiator outputs.
REQ-010 wbm_dat_i input 32, wbm_ack_i input 1: Wishbone responder return path.
REQ-011 busy_o output 1: high in any state other than IDLE.

Function
REQ-012 FSM SHALL have exactly three states: IDLE, BUS, RESP.
REQ-013 cmd_ready_o SHALL equal (state==IDLE), driven from state only, with no combinational path from cmd_valid_i.
REQ-014 IDLE->BUS SHALL occur on an edge where cmd_valid_i & cmd_ready_o; at that edge we/sel/adr/dat SHALL be registered onto wbm_we_o/sel_o/adr_o/dat_o.
REQ-015 wbm_cyc_o and wbm_stb_o SHALL both be 1 exactly while state==BUS, as registered outputs.
REQ-016 wbm_adr_o/sel_o/we_o/dat_o SHALL hold stable for the whole BUS state; outside BUS they SHALL hold their last value (no requirement to zero them).
REQ-017 In BUS, wbm_ack_i sampled 1 at an edge SHALL cause BUS->RESP, rsp_err_o<=0, rsp_data_o<=wbm_dat_i for reads and 32'h0 for writes.
REQ-018 In BUS, a 16-bit wait counter SHALL clear on entry and increment every cycle ack is 0.
REQ-019 When the counter reaches TIMEOUT with ack still 0, the FSM SHALL go BUS->RESP with rsp_err_o<=1, rsp_data_o<=ERR_DATA.
REQ-020 If ack is 1 on the same edge the timeout would fire, the ack SHALL take priority (normal completion, err=0).
REQ-021 wbm_ack_i SHALL be ignored in IDLE and RESP; a late ack after a timeout SHALL have no effect.
REQ-022 rsp_valid_o SHALL equal (state==RESP); rsp_data_o/rsp_err_o SHALL hold stable while rsp_valid_o=1.
REQ-023 RESP->IDLE SHALL occur on an edge where rsp_ready_i=1; otherwise the response SHALL be held indefinitely and no new command accepted.
REQ-024 Minimum latency: command accepted at edge N, stb high in cycle N+1, ack in N+1, rsp_valid_o=1 in cycle N+2, cmd_ready_o=1 one cycle after the response handshake.
REQ-025 Throughput SHALL be at most one transfer per 3 cycles; no pipelining, no burst (CTI/BTE unsupported).

Reset
REQ-026 wb_rst_n_i=0 SHALL immediately (asynchronously) force state=IDLE, wbm_cyc_o=wbm_stb_o=wbm_we_o=0, wbm_sel_o=0, wbm_adr_o=wbm_dat_o=0, rsp_valid_o=0, rsp_data_o=0, rsp_err_o=0, counter=0, busy_o=0.
REQ-027 Reset asserted mid-BUS SHALL drop cyc/stb in the same cycle; the in-flight transfer SHALL be discarded with no response.
REQ-028 After deassertion, cmd_ready_o SHALL be 1 from the first clock edge onward.

Verification
REQ-029 Write: cmd we=1 sel=4'hF adr=32'h3000_0004 dat=32'h1234_5678, ack in first stb cycle -> bus shows those values with cyc=stb=1 for 1 cycle; rsp_valid=1 next cycle, data=0, err=0.
REQ-030 Read with 3 wait cycles: adr=32'h3000_0000, ack asserted on 4th stb cycle with dat_i=32'hCAFE_F00D -> stb high 4 cycles, rsp_data=32'hCAFE_F00D, err=0.
REQ-031 Timeout with TIMEOUT=4, ack never asserted -> stb high exactly 4 cycles then drops; rsp_err=1, rsp_data=32'hDEAD_BEEF; a later ack pulse is ignored.
REQ-032 Ack and timeout collide (ack on the 4th cycle, TIMEOUT=4) -> err=0, data=wbm_dat_i.
REQ-033 Backpressure: rsp_ready=0 for 10 cycles with cmd_valid held 1 -> rsp fields stable, cmd_ready=0 throughout; second command accepted one cycle after rsp_ready=1.
REQ-034 Reset asserted during the 2nd wait cycle of a read -> cyc/stb=0 before the next edge, rsp_valid never asserts, cmd_ready=1 at the first edge after release.

Source files
------------

// File: rtl/wb_master_bridge.sv
// Single-outstanding command/response bridge onto a Wishbone classic initiator port.
// One transfer at a time: accept a command, run one bus cycle (ack or timeout), hold the response.
module wb_master_bridge #(
    parameter int unsigned TIMEOUT  = 255,
    parameter logic [31:0] ERR_DATA = 32'hDEAD_BEEF
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_n_i,

    // valid/ready: a transfer happens on a rising edge where both valid and ready are 1;
    // the sender holds valid and its fields stable until that edge, ready never depends on valid.
    input  logic        cmd_valid_i,
    output logic        cmd_ready_o,
    input  logic        cmd_we_i,
    input  logic [3:0]  cmd_sel_i,
    input  logic [31:0] cmd_adr_i,
    input  logic [31:0] cmd_dat_i,

    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_data_o,
    output logic        rsp_err_o,

    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic        wbm_we_o,
    output logic [3:0]  wbm_sel_o,
    output logic [31:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    input  logic [31:0] wbm_dat_i,
    input  logic        wbm_ack_i,

    output logic        busy_o,
    output logic [1:0]  dbg_state_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } state_t;

    // Counter value on the last allowed stb cycle; timing out here gives exactly TIMEOUT stb cycles.
    localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT - 1);

    state_t      state_q;
    state_t      state_d;
    logic [15:0] wait_cnt_q;

    logic cmd_fire;
    logic ack_hit;
    logic timeout_hit;
    logic rsp_fire;

    assign cmd_fire    = cmd_valid_i & (state_q == IDLE);
    assign ack_hit     = (state_q == BUS) & wbm_ack_i;
    assign timeout_hit = (state_q == BUS) & ~wbm_ack_i & (wait_cnt_q == WAIT_LAST);
    assign rsp_fire    = (state_q == RESP) & rsp_ready_i;

    assign cmd_ready_o = (state_q == IDLE);
    assign rsp_valid_o = (state_q == RESP);
    assign busy_o      = (state_q != IDLE);
    assign dbg_state_o = state_q;

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (cmd_fire) begin
                    state_d = BUS;
                end
            end
            BUS: begin
                if (ack_hit || timeout_hit) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                if (rsp_fire) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Bus-side registers: cyc/stb are flops of their own so they never glitch on state decode.
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            wbm_cyc_o <= 1'b0;
            wbm_stb_o <= 1'b0;
            wbm_we_o  <= 1'b0;
            wbm_sel_o <= 4'h0;
            wbm_adr_o <= 32'h0;
            wbm_dat_o <= 32'h0;
        end else if (cmd_fire) begin
            wbm_cyc_o <= 1'b1;
            wbm_stb_o <= 1'b1;
            wbm_we_o  <= cmd_we_i;
            wbm_sel_o <= cmd_sel_i;
            wbm_adr_o <= cmd_adr_i;
            wbm_dat_o <= cmd_dat_i;
        end else if (ack_hit || timeout_hit) begin
            wbm_cyc_o <= 1'b0;
            wbm_stb_o <= 1'b0;
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            wait_cnt_q <= 16'h0;
        end else if (cmd_fire) begin
            wait_cnt_q <= 16'h0;
        end else if ((state_q == BUS) && !wbm_ack_i) begin
            wait_cnt_q <= wait_cnt_q + 16'h1;
        end
    end

    // Ack is tested before timeout so a same-edge collision completes normally.
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            rsp_data_o <= 32'h0;
            rsp_err_o  <= 1'b0;
        end else if (ack_hit) begin
            rsp_data_o <= wbm_we_o ? 32'h0 : wbm_dat_i;
            rsp_err_o  <= 1'b0;
        end else if (timeout_hit) begin
            rsp_data_o <= ERR_DATA;
            rsp_err_o  <= 1'b1;
        end
    end

endmodule

// File: tb/tb_wb_master_bridge.sv
// Self-checking bench for wb_master_bridge: directed scenarios plus randomized transfers
// checked against a per-transfer outcome model (stb length, err flag, response data).
module tb_wb_master_bridge;

    localparam int          TMO  = 4;
    localparam logic [31:0] ERRD = 32'hDEAD_BEEF;
    localparam int          NO_ACK = 1000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_we = 1'b0;
    logic [3:0]  cmd_sel = 4'h0;
    logic [31:0] cmd_adr = 32'h0;
    logic [31:0] cmd_dat = 32'h0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_data;
    logic        rsp_err;
    logic        wbm_cyc;
    logic        wbm_stb;
    logic        wbm_we;
    logic [3:0]  wbm_sel;
    logic [31:0] wbm_adr;
    logic [31:0] wbm_dat_o;
    logic [31:0] wbm_dat_i = 32'h0;
    logic        wbm_ack = 1'b0;
    logic        busy;
    logic [1:0]  dbg_state;

    int checks = 0;
    int failures = 0;

    wb_master_bridge #(.TIMEOUT(TMO), .ERR_DATA(ERRD)) dut (
        .wb_clk_i    (clk),
        .wb_rst_n_i  (rst_n),
        .cmd_valid_i (cmd_valid),
        .cmd_ready_o (cmd_ready),
        .cmd_we_i    (cmd_we),
        .cmd_sel_i   (cmd_sel),
        .cmd_adr_i   (cmd_adr),
        .cmd_dat_i   (cmd_dat),
        .rsp_valid_o (rsp_valid),
        .rsp_ready_i (rsp_ready),
        .rsp_data_o  (rsp_data),
        .rsp_err_o   (rsp_err),
        .wbm_cyc_o   (wbm_cyc),
        .wbm_stb_o   (wbm_stb),
        .wbm_we_o    (wbm_we),
        .wbm_sel_o   (wbm_sel),
        .wbm_adr_o   (wbm_adr),
        .wbm_dat_o   (wbm_dat_o),
        .wbm_dat_i   (wbm_dat_i),
        .wbm_ack_i   (wbm_ack),
        .busy_o      (busy),
        .dbg_state_o (dbg_state)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full transfer. ack_delay = wait cycles before ack (NO_ACK = never).
    task automatic do_txn(input logic we, input logic [3:0] sel, input logic [31:0] adr,
                          input logic [31:0] dat, input int ack_delay, input int rsp_wait,
                          input logic hold_cmd, input logic late_ack);
        logic [31:0] rd;
        logic [31:0] exp_data;
        logic        exp_err;
        int          exp_stb;
        int          stb_cycles;
        rd       = $urandom;
        exp_err  = (ack_delay + 1 > TMO);
        exp_stb  = exp_err ? TMO : ack_delay + 1;
        exp_data = exp_err ? ERRD : (we ? 32'h0 : rd);

        checks++;
        if (cmd_ready !== 1'b1) begin
            failures++;
            $display("FAIL cmd_ready_idle: got %b want 1", cmd_ready);
        end
        cmd_valid = 1'b1;
        cmd_we = we; cmd_sel = sel; cmd_adr = adr; cmd_dat = dat;
        tick();
        cmd_valid = 1'b0;
        cmd_we = ~we; cmd_sel = ~sel; cmd_adr = $urandom; cmd_dat = $urandom;

        checks++;
        if ({wbm_cyc, wbm_stb, busy, cmd_ready, rsp_valid} !== 5'b11100) begin
            failures++;
            $display("FAIL bus_accept: cyc/stb/busy/cmd_ready/rsp_valid got %b want 11100",
                     {wbm_cyc, wbm_stb, busy, cmd_ready, rsp_valid});
        end

        stb_cycles = 0;
        while (wbm_stb === 1'b1 && stb_cycles < 100) begin
            stb_cycles++;
            checks++;
            if ({wbm_cyc, wbm_we, wbm_sel, wbm_adr, wbm_dat_o} !== {1'b1, we, sel, adr, dat}) begin
                failures++;
                $display("FAIL bus_fields: cycle %0d got cyc=%b we=%b sel=%h adr=%h dat=%h want we=%b sel=%h adr=%h dat=%h",
                         stb_cycles, wbm_cyc, wbm_we, wbm_sel, wbm_adr, wbm_dat_o, we, sel, adr, dat);
            end
            wbm_ack   = (stb_cycles == ack_delay + 1);
            wbm_dat_i = wbm_ack ? rd : $urandom;
            tick();
            wbm_ack = 1'b0;
        end

        checks++;
        if (stb_cycles != exp_stb || wbm_cyc !== 1'b0) begin
            failures++;
            $display("FAIL stb_cycles: got %0d (cyc=%b) want %0d", stb_cycles, wbm_cyc, exp_stb);
        end
        checks++;
        if ({rsp_valid, rsp_err, rsp_data} !== {1'b1, exp_err, exp_data}) begin
            failures++;
            $display("FAIL rsp_fields: valid=%b err=%b data=%h want valid=1 err=%b data=%h",
                     rsp_valid, rsp_err, rsp_data, exp_err, exp_data);
        end

        for (int i = 0; i < rsp_wait; i++) begin
            rsp_ready = 1'b0;
            cmd_valid = hold_cmd;
            wbm_ack   = late_ack;
            wbm_dat_i = $urandom;
            tick();
            wbm_ack = 1'b0;
            checks++;
            if ({rsp_valid, rsp_err, rsp_data, cmd_ready, wbm_stb} !== {1'b1, exp_err, exp_data, 1'b0, 1'b0}) begin
                failures++;
                $display("FAIL rsp_hold: wait %0d valid=%b err=%b data=%h cmd_ready=%b stb=%b want 1 %b %h 0 0",
                         i, rsp_valid, rsp_err, rsp_data, cmd_ready, wbm_stb, exp_err, exp_data);
            end
        end

        rsp_ready = 1'b1;
        cmd_valid = hold_cmd;
        tick();
        rsp_ready = 1'b0;
        checks++;
        if ({rsp_valid, cmd_ready, busy, wbm_stb} !== 4'b0100) begin
            failures++;
            $display("FAIL rsp_done: rsp_valid/cmd_ready/busy/stb got %b want 0100",
                     {rsp_valid, cmd_ready, busy, wbm_stb});
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #2;
        checks++;
        if ({wbm_cyc, wbm_stb, wbm_we, wbm_sel, wbm_adr, wbm_dat_o, rsp_valid, rsp_data, rsp_err, busy} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: cyc=%b stb=%b we=%b sel=%h adr=%h dat=%h rv=%b rd=%h re=%b busy=%b want all 0",
                     wbm_cyc, wbm_stb, wbm_we, wbm_sel, wbm_adr, wbm_dat_o, rsp_valid, rsp_data, rsp_err, busy);
        end
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        tick();
        checks++;
        if ({cmd_ready, busy, rsp_valid} !== 3'b100) begin
            failures++;
            $display("FAIL reset_release: cmd_ready/busy/rsp_valid got %b want 100", {cmd_ready, busy, rsp_valid});
        end
    endtask

    task automatic test_write_single();
        do_txn(1'b1, 4'hF, 32'h3000_0004, 32'h1234_5678, 0, 0, 1'b0, 1'b0);
    endtask

    task automatic test_read_wait();
        do_txn(1'b0, 4'hF, 32'h3000_0000, 32'h0, 3, 1, 1'b0, 1'b0);
    endtask

    task automatic test_timeout();
        do_txn(1'b0, 4'h3, 32'h3000_0010, 32'h0, NO_ACK, 3, 1'b0, 1'b1);
    endtask

    task automatic test_collision();
        do_txn(1'b0, 4'hC, 32'h3000_0020, 32'h0, TMO - 1, 0, 1'b0, 1'b0);
        do_txn(1'b1, 4'h1, 32'h3000_0024, 32'hA5A5_5A5A, TMO - 1, 0, 1'b0, 1'b0);
    endtask

    task automatic test_backpressure();
        do_txn(1'b0, 4'hF, 32'h4000_0000, 32'h0, 1, 10, 1'b1, 1'b0);
        do_txn(1'b1, 4'h6, 32'h4000_0008, 32'h0BAD_F00D, 0, 0, 1'b0, 1'b0);
    endtask

    task automatic test_reset_mid_bus();
        logic seen_rsp;
        cmd_valid = 1'b1; cmd_we = 1'b0; cmd_sel = 4'hF; cmd_adr = 32'h5000_0000;
        tick();
        cmd_valid = 1'b0;
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({wbm_cyc, wbm_stb, rsp_valid, busy, cmd_ready} !== 5'b00001) begin
            failures++;
            $display("FAIL reset_mid_bus: cyc/stb/rsp_valid/busy/cmd_ready got %b want 00001",
                     {wbm_cyc, wbm_stb, rsp_valid, busy, cmd_ready});
        end
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        tick();
        checks++;
        if ({cmd_ready, busy} !== 2'b10) begin
            failures++;
            $display("FAIL reset_mid_release: cmd_ready/busy got %b want 10", {cmd_ready, busy});
        end
        seen_rsp = 1'b0;
        for (int i = 0; i < 6; i++) begin
            wbm_ack = 1'b1;
            tick();
            seen_rsp = seen_rsp | rsp_valid | wbm_stb;
        end
        wbm_ack = 1'b0;
        checks++;
        if (seen_rsp !== 1'b0) begin
            failures++;
            $display("FAIL reset_discard: rsp_valid/stb seen after reset got %b want 0", seen_rsp);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 24; n++) begin
            int dly;
            dly = ($urandom_range(0, 7) == 0) ? NO_ACK : int'($urandom_range(0, 6));
            do_txn(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom, $urandom,
                   dly, int'($urandom_range(0, 3)), 1'b0, 1'($urandom_range(0, 1)));
        end
    endtask

    initial begin
        test_reset();
        test_write_single();
        test_read_wait();
        test_timeout();
        test_collision();
        test_backpressure();
        test_reset_mid_bus();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
